// File: rtl/posit_seq_pkg.sv
// Shared definitions for the posit batch sequencer.
//   ADDR_W    - on-chip RAM word-address width
//   DATA_W    - RAM and posit word width
//   MAX_PAIRS - largest operand-pair count a batch may process
//   state_t   - sequencer FSM state encoding
package posit_seq_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int MAX_PAIRS = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_ISSUE,
    S_WAIT_RES,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/posit_batch_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours:
//   m0_*  - memory-0 second port (operands, read only)
//   m1_*  - memory-1 second port (results, write only)
//   op_*  - operand handshake toward the posit arithmetic unit
//   res_* - result handshake back from the posit arithmetic unit
// Modport master is the sequencer side, slave the memory/arithmetic side.
interface posit_batch_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] m0_address;
  logic              m0_chipselect;
  logic              m0_clken;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic [1:0]        m0_byteenable;
  logic [DATA_W-1:0] m0_readdata;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_chipselect;
  logic              m1_clken;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [1:0]        m1_byteenable;
  logic [DATA_W-1:0] m1_readdata;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (
    output m0_address, m0_chipselect, m0_clken, m0_write, m0_writedata, m0_byteenable,
    input  m0_readdata,
    output m1_address, m1_chipselect, m1_clken, m1_write, m1_writedata, m1_byteenable,
    input  m1_readdata,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  res_valid, res_data,
    output res_ready
  );

  modport slave (
    input  m0_address, m0_chipselect, m0_clken, m0_write, m0_writedata, m0_byteenable,
    output m0_readdata,
    input  m1_address, m1_chipselect, m1_clken, m1_write, m1_writedata, m1_byteenable,
    output m1_readdata,
    input  op_valid, op_a, op_b,
    output op_ready,
    output res_valid, res_data,
    input  res_ready
  );

endinterface

// File: rtl/posit_batch_sequencer_rise_detect.sv
// One-register rising-edge detector.
//   clk, reset_n - clock and asynchronous active-low reset
//   d            - level input
//   rise         - high for the cycle in which d is 1 and was 0 the cycle before
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/posit_batch_sequencer.sv
// Batch sequencer: on a start rise, streams operand pairs from memory 0
// through the posit arithmetic unit and stores results in memory 1.
//   clk, reset_n - clock and asynchronous active-low reset
//   start        - start level; a rising edge launches a batch
//   soft_reset   - synchronous abort back to IDLE
//   op_count     - pairs in the batch, clamped to MAX_PAIRS
//   done         - batch complete
//   cycles       - busy-cycle count of the last batch (saturating)
//   bus          - memory ports and arithmetic-unit handshakes
module posit_batch_sequencer
  import posit_seq_pkg::*;
#(
  parameter int ADDR_W    = posit_seq_pkg::ADDR_W,
  parameter int DATA_W    = posit_seq_pkg::DATA_W,
  parameter int MAX_PAIRS = posit_seq_pkg::MAX_PAIRS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              soft_reset,
  input  logic [ADDR_W-1:0] op_count,
  output logic              done,
  output logic [31:0]       cycles,
  posit_batch_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_PAIRS);

  state_t            state, state_n;
  logic              start_rise;
  logic              launch;
  logic              busy;
  logic              last_pair;
  logic [ADDR_W-1:0] count_clamped;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic              unused_m1;

  rise_detect u_start_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (start),
    .rise    (start_rise)
  );

  assign count_clamped = (op_count > MAX_CNT) ? MAX_CNT : op_count;
  // A rise only counts when no batch is in progress.
  assign launch    = start_rise && (state == S_IDLE || state == S_DONE) && !soft_reset;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign last_pair = (idx + 1'b1) == cnt;

  assign bus.m0_write      = 1'b0;
  assign bus.m0_writedata  = '0;
  assign bus.m0_byteenable = 2'b11;
  assign bus.m1_byteenable = 2'b11;
  assign bus.m1_writedata  = res_q;
  assign bus.op_a          = a_q;
  assign bus.op_b          = b_q;
  assign unused_m1         = ^bus.m1_readdata;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cycles <= '0;
    end else begin
      state <= state_n;
      if (soft_reset) begin
        cycles <= '0;
      end else if (launch) begin
        cnt    <= count_clamped;
        idx    <= '0;
        cycles <= '0;
      end else begin
        if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
        case (state)
          S_RD_B:     a_q <= bus.m0_readdata;
          S_CAP_B:    b_q <= bus.m0_readdata;
          S_WAIT_RES: if (bus.res_valid) res_q <= bus.res_data;
          S_WRITE:    idx <= idx + 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n           = state;
    done              = 1'b0;
    bus.m0_address    = '0;
    bus.m0_chipselect = 1'b0;
    bus.m0_clken      = 1'b0;
    bus.m1_address    = '0;
    bus.m1_chipselect = 1'b0;
    bus.m1_clken      = 1'b0;
    bus.m1_write      = 1'b0;
    bus.op_valid      = 1'b0;
    bus.res_ready     = 1'b0;

    case (state)
      S_IDLE: begin
        bus.res_ready = 1'b1;  // drain any stale result
        if (launch) state_n = (count_clamped == '0) ? S_DONE : S_RD_A;
      end
      S_RD_A: begin
        bus.m0_address    = {idx[ADDR_W-2:0], 1'b0};
        bus.m0_chipselect = 1'b1;
        bus.m0_clken      = 1'b1;
        state_n           = S_RD_B;
      end
      S_RD_B: begin
        bus.m0_address    = {idx[ADDR_W-2:0], 1'b1};
        bus.m0_chipselect = 1'b1;
        bus.m0_clken      = 1'b1;
        state_n           = S_CAP_B;
      end
      S_CAP_B: state_n = S_ISSUE;
      S_ISSUE: begin
        bus.op_valid = 1'b1;
        if (bus.op_ready) state_n = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        bus.res_ready = 1'b1;
        if (bus.res_valid) state_n = S_WRITE;
      end
      S_WRITE: begin
        bus.m1_address    = idx;
        bus.m1_chipselect = 1'b1;
        bus.m1_clken      = 1'b1;
        bus.m1_write      = 1'b1;
        state_n           = last_pair ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done = 1'b1;
        if (launch) state_n = (count_clamped == '0) ? S_DONE : S_RD_A;
      end
      default: state_n = S_IDLE;
    endcase

    // Abort wins over everything: quiet all strobes and head back to IDLE.
    if (soft_reset) begin
      state_n           = S_IDLE;
      done              = 1'b0;
      bus.m0_address    = '0;
      bus.m0_chipselect = 1'b0;
      bus.m0_clken      = 1'b0;
      bus.m1_address    = '0;
      bus.m1_chipselect = 1'b0;
      bus.m1_clken      = 1'b0;
      bus.m1_write      = 1'b0;
      bus.op_valid      = 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_batch_sequencer.sv
// Directed testbench for posit_batch_sequencer: memory-0 model with one-cycle
// read latency, memory-1 write logger, and an arithmetic-unit model with
// programmable op_ready / res_valid delays returning a ^ b ^ 16'h5000.
module tb_posit_batch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        soft_reset = 1'b0;
  logic [10:0] op_count = '0;
  logic        done;
  logic [31:0] cycles;

  posit_batch_sequencer_if bus ();

  posit_batch_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .soft_reset (soft_reset),
    .op_count   (op_count),
    .done       (done),
    .cycles     (cycles),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int strobe_cnt = 0;
  int clash_cnt = 0;
  logic [10:0] last_rd_addr = '0;
  logic [10:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] mem0 [0:2047];

  int op_delay = 0;
  int res_delay = 0;
  int op_wait = 0;
  int res_wait = 0;
  logic        pending = 1'b0;
  logic [15:0] res_reg = '0;
  logic [15:0] last_op_a = '0;
  logic [15:0] last_op_b = '0;

  assign bus.op_ready    = (op_wait >= op_delay);
  assign bus.res_valid   = pending && (res_wait >= res_delay);
  assign bus.res_data    = res_reg;
  assign bus.m1_readdata = '0;

  // memory 0: one-cycle read latency
  always @(posedge clk) begin
    if (bus.m0_chipselect && bus.m0_clken) bus.m0_readdata <= mem0[bus.m0_address];
  end

  // arithmetic unit
  always @(posedge clk) begin
    if (bus.res_valid && bus.res_ready) pending <= 1'b0;
    else if (pending && !bus.res_valid) res_wait <= res_wait + 1;
    if (bus.op_valid && bus.op_ready) begin
      pending   <= 1'b1;
      res_wait  <= 0;
      op_wait   <= 0;
      res_reg   <= bus.op_a ^ bus.op_b ^ 16'h5000;
      last_op_a <= bus.op_a;
      last_op_b <= bus.op_b;
    end else if (bus.op_valid) begin
      op_wait <= op_wait + 1;
    end
  end

  // bus monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.m1_write && bus.m1_chipselect && bus.m1_clken) begin
      wr_addr.push_back(bus.m1_address);
      wr_data.push_back(bus.m1_writedata);
      last_wr_cyc <= cyc;
    end
    if (bus.m0_chipselect) last_rd_addr <= bus.m0_address;
    if (bus.m0_chipselect || bus.m1_chipselect) strobe_cnt <= strobe_cnt + 1;
    if (bus.m0_chipselect && bus.m1_chipselect) clash_cnt <= clash_cnt + 1;
  end

  function automatic logic [15:0] q_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 16'hxxxx;
  endfunction

  function automatic logic [10:0] q_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 11'hxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start rises in the current cycle and drops after one cycle
  task automatic kick(input int n);
    op_count  = 11'(n);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) break;
      tick();
    end
    done_cyc = cyc;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_timeout: got %b want 1", tag, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    vectors++; if (bus.op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_op_valid: got %b want 0", bus.op_valid); end
    vectors++; if (bus.m0_chipselect !== 1'b0) begin miscompares++; $display("FAIL reset_m0_cs: got %b want 0", bus.m0_chipselect); end
    vectors++; if (bus.m1_write !== 1'b0) begin miscompares++; $display("FAIL reset_m1_write: got %b want 0", bus.m1_write); end
    vectors++; if (bus.m0_byteenable !== 2'b11) begin miscompares++; $display("FAIL reset_m0_be: got %b want 11", bus.m0_byteenable); end
    vectors++; if (bus.m1_byteenable !== 2'b11) begin miscompares++; $display("FAIL reset_m1_be: got %b want 11", bus.m1_byteenable); end
    reset_n = 1'b1;
    repeat (2) tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL idle_done: got %b want 0", done); end
  endtask

  task automatic test_zero_count();
    int s0;
    s0 = strobe_cnt;
    kick(0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done_next_cycle: got %b want 1", done); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL zero_cycles: got %0d want 0", cycles); end
    repeat (4) tick();
    vectors++; if (strobe_cnt !== s0) begin miscompares++; $display("FAIL zero_strobes: got %0d want %0d", strobe_cnt - s0, 0); end
  endtask

  task automatic test_single();
    mem0[0] = 16'h4000;
    mem0[1] = 16'h4000;
    op_delay = 0; res_delay = 0;
    wr_addr.delete(); wr_data.delete();
    kick(1);
    wait_done(50, "single");
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL single_wr_count: got %0d want 1", wr_addr.size()); end
    vectors++; if (q_addr(0) !== 11'd0) begin miscompares++; $display("FAIL single_wr_addr: got %0h want 0", q_addr(0)); end
    vectors++; if (q_data(0) !== 16'h5000) begin miscompares++; $display("FAIL single_wr_data: got %h want 5000", q_data(0)); end
    vectors++; if (cycles !== 32'd6) begin miscompares++; $display("FAIL single_cycles: got %0d want 6", cycles); end
    vectors++; if (done_cyc !== last_wr_cyc + 1) begin miscompares++; $display("FAIL single_done_timing: got %0d want %0d", done_cyc, last_wr_cyc + 1); end
    vectors++; if (last_op_a !== 16'h4000) begin miscompares++; $display("FAIL single_op_a: got %h want 4000", last_op_a); end
    vectors++; if (last_op_b !== 16'h4000) begin miscompares++; $display("FAIL single_op_b: got %h want 4000", last_op_b); end
  endtask

  task automatic test_four_delayed();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      mem0[2*i]   = 16'h0100 + 16'(i);
      mem0[2*i+1] = 16'h3000 + 16'(i * 16);
    end
    op_delay = 3; res_delay = 0;
    wr_addr.delete(); wr_data.delete();
    kick(4);
    wait_done(200, "four");
    vectors++; if (wr_addr.size() !== 4) begin miscompares++; $display("FAIL four_wr_count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = mem0[2*i] ^ mem0[2*i+1] ^ 16'h5000;
      vectors++; if (q_addr(i) !== 11'(i)) begin miscompares++; $display("FAIL four_wr_addr[%0d]: got %0h want %0h", i, q_addr(i), i); end
      vectors++; if (q_data(i) !== exp) begin miscompares++; $display("FAIL four_wr_data[%0d]: got %h want %h", i, q_data(i), exp); end
    end
    vectors++; if (cycles !== 32'd36) begin miscompares++; $display("FAIL four_cycles: got %0d want 36", cycles); end
    op_delay = 0;
  endtask

  task automatic test_soft_reset();
    bit found;
    for (int i = 0; i < 10; i++) mem0[i] = 16'h0A00 + 16'(i);
    op_delay = 0; res_delay = 4;
    wr_addr.delete(); wr_data.delete();
    kick(5);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (wr_addr.size() == 1 && bus.res_ready === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL sr_reach_wait_res: got %b want 1", found); end
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL sr_done: got %b want 0", done); end
    vectors++; if (cycles !== 32'd0) begin miscompares++; $display("FAIL sr_cycles: got %0d want 0", cycles); end
    vectors++; if (bus.op_valid !== 1'b0) begin miscompares++; $display("FAIL sr_op_valid: got %b want 0", bus.op_valid); end
    repeat (10) tick();
    vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL sr_result_drained: got %b want 0", pending); end
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL sr_no_extra_write: got %0d want 1", wr_addr.size()); end
    res_delay = 0;
    mem0[0] = 16'h1234;
    mem0[1] = 16'h00FF;
    wr_addr.delete(); wr_data.delete();
    kick(1);
    wait_done(50, "sr_restart");
    vectors++; if (q_data(0) !== 16'h42CB) begin miscompares++; $display("FAIL sr_restart_data: got %h want 42cb", q_data(0)); end
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL sr_restart_count: got %0d want 1", wr_addr.size()); end
    vectors++; if (cycles !== 32'd6) begin miscompares++; $display("FAIL sr_restart_cycles: got %0d want 6", cycles); end
  endtask

  task automatic test_start_held();
    op_delay = 0; res_delay = 0;
    wr_addr.delete(); wr_data.delete();
    op_count = 11'd2;
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    tick();
    start = 1'b1;  // second rise while busy: ignored
    wait_done(100, "held");
    vectors++; if (cycles !== 32'd12) begin miscompares++; $display("FAIL held_cycles: got %0d want 12", cycles); end
    repeat (5) tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL held_done_stays: got %b want 1", done); end
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL held_one_batch: got %0d want 2", wr_addr.size()); end
    vectors++; if (cycles !== 32'd12) begin miscompares++; $display("FAIL held_no_retrigger: got %0d want 12", cycles); end
    start = 1'b0;
    tick();
    wr_addr.delete(); wr_data.delete();
    start = 1'b1;
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL held_restart_clears_done: got %b want 0", done); end
    wait_done(100, "held_restart");
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL held_restart_count: got %0d want 2", wr_addr.size()); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    int order_err;
    logic [15:0] exp;
    for (int i = 0; i < 2048; i++) mem0[i] = 16'(i * 37 + 5);
    op_delay = 0; res_delay = 0;
    wr_addr.delete(); wr_data.delete();
    kick(2000);
    wait_done(7000, "clamp");
    vectors++; if (cycles !== 32'd6144) begin miscompares++; $display("FAIL clamp_cycles: got %0d want 6144", cycles); end
    vectors++; if (wr_addr.size() !== 1024) begin miscompares++; $display("FAIL clamp_wr_count: got %0d want 1024", wr_addr.size()); end
    vectors++; if (q_addr(1023) !== 11'd1023) begin miscompares++; $display("FAIL clamp_last_wr_addr: got %0d want 1023", q_addr(1023)); end
    exp = mem0[2046] ^ mem0[2047] ^ 16'h5000;
    vectors++; if (q_data(1023) !== exp) begin miscompares++; $display("FAIL clamp_last_wr_data: got %h want %h", q_data(1023), exp); end
    vectors++; if (last_rd_addr !== 11'd2047) begin miscompares++; $display("FAIL clamp_last_rd_addr: got %0d want 2047", last_rd_addr); end
    order_err = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] !== 11'(i)) order_err++;
    vectors++; if (order_err !== 0) begin miscompares++; $display("FAIL clamp_wr_order: got %0d bad want 0", order_err); end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_single();
    test_four_delayed();
    test_soft_reset();
    test_start_held();
    test_clamp();
    vectors++; if (clash_cnt !== 0) begin miscompares++; $display("FAIL m0_m1_same_cycle: got %0d want 0", clash_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
